audio_sample_fifo: RTL and testbench

Elastic buffer between the audio generator and the I2S serializer. Accepts stereo sample pairs from the generator on a valid/ready handshake at arbitrary times, stores them in a small FIFO, and presents exactly one pair per audio frame to the I2S controller's parallel inputs, timed from the controller's own LRCLK. A prime/run state machine absorbs jitter between the generator's sample rate and the codec's sample rate.

---
 rtl/audio_sample_fifo.sv | 106 ++++++++++
 tb/tb_audio_sample_fifo.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_fifo.sv
// Stereo sample elastic buffer: generator pushes pairs, one pair is popped per I2S frame (LRCLK fall).
// Optional underrun counter port/logic enabled by defining AUDIO_FIFO_STATS_EN.
module audio_sample_fifo #(
  parameter int WIDTH      = 24,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_l,
  input  logic [WIDTH-1:0]      in_r,
  input  logic                  lrclk,
  output logic [WIDTH-1:0]      out_l,
  output logic [WIDTH-1:0]      out_r,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  running,
  output logic                  underrun
`ifdef AUDIO_FIFO_STATS_EN
  ,
  output logic [15:0]           underrun_count
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] THRESH = (DEPTH_LOG2+1)'(DEPTH / 2);

  typedef enum logic {FILL, RUN} state_t;
  state_t state;

  logic [2*WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH_LOG2:0] wptr, rptr, wptr_nxt, rptr_nxt;
  logic                s1, s2, s3;
  logic                fs, full, empty, push, pop, ur_evt;

  assign full     = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) &&
                    (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);
  assign empty    = (wptr == rptr);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign fs       = s3 && !s2;
  // No bypass: a pair pushed on the strobe cycle is not visible to that strobe.
  assign pop      = (state == RUN) && fs && !empty;
  assign ur_evt   = (state == RUN) && fs && empty;
  assign wptr_nxt = wptr + {{DEPTH_LOG2{1'b0}}, push};
  assign rptr_nxt = rptr + {{DEPTH_LOG2{1'b0}}, pop};
  assign running  = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= lrclk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[DEPTH_LOG2-1:0]] <= {in_l, in_r};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      out_l    <= '0;
      out_r    <= '0;
      underrun <= 1'b0;
    end else begin
      wptr     <= wptr_nxt;
      rptr     <= rptr_nxt;
      level    <= wptr_nxt - rptr_nxt;
      underrun <= 1'b0;
      case (state)
        FILL: begin
          out_l <= '0;
          out_r <= '0;
          if (level >= THRESH) state <= RUN;
        end
        RUN: begin
          if (pop) begin
            {out_l, out_r} <= mem[rptr[DEPTH_LOG2-1:0]];
          end else if (ur_evt) begin
            underrun <= 1'b1;
            out_l    <= '0;
            out_r    <= '0;
            state    <= FILL;
          end
        end
      endcase
    end
  end

`ifdef AUDIO_FIFO_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) underrun_count <= '0;
    else if (ur_evt && underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed bench for audio_sample_fifo: fill/run, strobe latency, full, underrun, same-cycle push/pop, reset.
module tb_audio_sample_fifo;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_l = '0, in_r = '0;
  logic        lrclk = 1'b0;
  logic [23:0] out_l, out_r;
  logic [4:0]  level;
  logic        running, underrun;
`ifdef AUDIO_FIFO_STATS_EN
  logic [15:0] underrun_count;
`endif

  int errors = 0;
  int checks = 0;

  audio_sample_fifo #(.WIDTH(24), .DEPTH_LOG2(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_l(in_l), .in_r(in_r), .lrclk(lrclk), .out_l(out_l), .out_r(out_r),
    .level(level), .running(running), .underrun(underrun)
`ifdef AUDIO_FIFO_STATS_EN
    , .underrun_count(underrun_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full frame: high half then falling edge; the pop lands on the 3rd edge of the low half.
  task automatic frame();
    lrclk = 1'b1;
    repeat (4) tick();
    lrclk = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_l !== 24'h0 || out_r !== 24'h0) begin errors++; $display("FAIL reset_out got=%h/%h exp=0/0", out_l, out_r); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b exp=0", running); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
`ifdef AUDIO_FIFO_STATS_EN
    checks++; if (underrun_count !== 16'd0) begin errors++; $display("FAIL reset_ucount got=%0d exp=0", underrun_count); end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 7; i++) begin
      in_valid = 1'b1;
      in_l = 24'(i);
      in_r = 24'h100000 + 24'(i);
      tick();
    end
    in_valid = 1'b0;
    repeat (4) frame();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL fill_running got=%b exp=0", running); end
    checks++; if (out_l !== 24'h0 || out_r !== 24'h0) begin errors++; $display("FAIL fill_out got=%h/%h exp=0/0", out_l, out_r); end
    checks++; if (level !== 5'd7) begin errors++; $display("FAIL fill_level got=%0d exp=7", level); end
  endtask

  task automatic test_run_start();
    in_valid = 1'b1;
    in_l = 24'd8;
    in_r = 24'h100008;
    tick();
    in_valid = 1'b0;
    checks++; if (level !== 5'd8 || running !== 1'b0) begin errors++; $display("FAIL start_level8 got=%0d/%b exp=8/0", level, running); end
    tick();
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL start_running got=%b exp=1", running); end
    lrclk = 1'b1;
    repeat (4) tick();
    lrclk = 1'b0;
    tick();
    checks++; if (out_l !== 24'h0) begin errors++; $display("FAIL start_edge1 got=%h exp=0", out_l); end
    tick();
    checks++; if (out_l !== 24'h0) begin errors++; $display("FAIL start_edge2 got=%h exp=0", out_l); end
    tick();
    checks++; if (out_l !== 24'h000001 || out_r !== 24'h100001) begin errors++; $display("FAIL start_edge3 got=%h/%h exp=000001/100001", out_l, out_r); end
    checks++; if (level !== 5'd7) begin errors++; $display("FAIL start_level got=%0d exp=7", level); end
  endtask

  task automatic test_push_pop_same_cycle();
    frame();
    frame();
    checks++; if (level !== 5'd5 || out_l !== 24'd3) begin errors++; $display("FAIL pp_pre got=%0d/%h exp=5/000003", level, out_l); end
    lrclk = 1'b1;
    repeat (4) tick();
    lrclk = 1'b0;
    tick();
    tick();
    in_valid = 1'b1;
    in_l = 24'h0000AA;
    in_r = 24'h0000BB;
    tick();
    in_valid = 1'b0;
    checks++; if (level !== 5'd5) begin errors++; $display("FAIL pp_level got=%0d exp=5", level); end
    checks++; if (out_l !== 24'd4 || out_r !== 24'h100004) begin errors++; $display("FAIL pp_oldest got=%h/%h exp=000004/100004", out_l, out_r); end
  endtask

  task automatic test_underrun();
    repeat (5) frame();
    checks++; if (out_l !== 24'h0000AA || out_r !== 24'h0000BB || level !== 5'd0) begin errors++; $display("FAIL ur_drain got=%h/%h lvl=%0d exp=0000aa/0000bb lvl=0", out_l, out_r, level); end
    lrclk = 1'b1;
    repeat (4) tick();
    lrclk = 1'b0;
    tick();
    tick();
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_early got=%b exp=0", underrun); end
    tick();
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_pulse got=%b exp=1", underrun); end
    checks++; if (out_l !== 24'h0 || out_r !== 24'h0 || running !== 1'b0) begin errors++; $display("FAIL ur_state got=%h/%h run=%b exp=0/0 run=0", out_l, out_r, running); end
`ifdef AUDIO_FIFO_STATS_EN
    checks++; if (underrun_count !== 16'd1) begin errors++; $display("FAIL ur_count got=%0d exp=1", underrun_count); end
`endif
    tick();
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_width got=%b exp=0", underrun); end
  endtask

  task automatic test_full();
    int acc;
    logic rdy;
    acc = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_l = 24'h000100 + 24'(acc);
      in_r = 24'h000200 + 24'(acc);
      rdy = in_ready;
      tick();
      if (rdy) acc++;
    end
    checks++; if (acc != 16) begin errors++; $display("FAIL full_accepted got=%0d exp=16", acc); end
    checks++; if (level !== 5'd16 || in_ready !== 1'b0) begin errors++; $display("FAIL full_state got=%0d/%b exp=16/0", level, in_ready); end
    lrclk = 1'b1;
    repeat (4) tick();
    lrclk = 1'b0;
    repeat (3) tick();
    checks++; if (out_l !== 24'h000100 || in_ready !== 1'b1 || level !== 5'd15) begin errors++; $display("FAIL full_pop got=%h rdy=%b lvl=%0d exp=000100 rdy=1 lvl=15", out_l, in_ready, level); end
    tick();
    in_valid = 1'b0;
    checks++; if (level !== 5'd16 || in_ready !== 1'b0) begin errors++; $display("FAIL full_17th got=%0d/%b exp=16/0", level, in_ready); end
  endtask

  task automatic test_reset_mid();
    int fs_seen;
    repeat (6) frame();
    checks++; if (level !== 5'd10 || out_l !== 24'h000106) begin errors++; $display("FAIL rm_pre got=%0d/%h exp=10/000106", level, out_l); end
    lrclk = 1'b1;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_l !== 24'h0 || out_r !== 24'h0 || level !== 5'd0) begin errors++; $display("FAIL rm_async got=%h/%h lvl=%0d exp=0/0 lvl=0", out_l, out_r, level); end
    checks++; if (running !== 1'b0 || in_ready !== 1'b1 || underrun !== 1'b0) begin errors++; $display("FAIL rm_flags got=run%b rdy%b ur%b exp=run0 rdy1 ur0", running, in_ready, underrun); end
    #10 rst_n = 1'b1;
    fs_seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (dut.fs) fs_seen++;
    end
    checks++; if (fs_seen != 0) begin errors++; $display("FAIL rm_stale_strobe got=%0d exp=0", fs_seen); end
    checks++; if (level !== 5'd0 || running !== 1'b0) begin errors++; $display("FAIL rm_after got=%0d/%b exp=0/0", level, running); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_run_start();
    test_push_pop_same_cycle();
    test_underrun();
    test_full();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
